// File: rtl/dac_pkg.sv
// dac_pkg
//   Shared definitions for the audio DAC serial transmit path.
//   Holds the FSM state encoding, the default frame geometry and a small helper
//   for sizing counters.
//   Build option: DAC_LDAC_EN (see dac_spi_tx) does not change anything here.

package dac_pkg;

    // Default frame geometry: 16-bit samples, sclk half-period of 114 cycles
    // for a 100 MHz system clock, and the minimum cs-high gap between frames.
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned CLK_DIV_DEF     = 114;
    localparam int unsigned CS_HIGH_CYC_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width needed to hold the values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sclk_phase_cnt.sv
// sclk_phase_cnt
//   Loadable down-counter used for every timed interval of the DAC frame
//   (cs setup, each sclk half-period, cs hold and the inter-frame gap).
//   Loading value N-1 produces a single-cycle tick during the N-th cycle after
//   the load edge, so the owner changes state exactly N cycles after loading.
// Ports
//   clk       in   1      system clock
//   reset     in   1      synchronous, active-high reset (disarms the counter)
//   load      in   1      start a new interval
//   load_val  in   CNT_W  interval length minus one
//   tick      out  1      high for one cycle on the last cycle of the interval

module sclk_phase_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] count;
    logic             armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            armed <= 1'b0;
        end else if (load) begin
            count <= load_val;
            armed <= 1'b1;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end else begin
            // Interval finished without a reload: stay quiet until loaded again.
            armed <= 1'b0;
        end
    end

    assign tick = armed && (count == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx
//   Serial transmitter for the audio DAC. Accepts one DATA_W-bit sample per
//   valid/ready handshake and shifts it out MSB first on cs/sclk/sdata.
//   Frame: SETUP (cs low, CLK_DIV cycles) -> DATA_W bits of sclk low/high
//   (CLK_DIV cycles each phase) -> HOLD (CLK_DIV cycles) -> GAP (cs high)
//   -> IDLE. All outputs are registered.
// Build option
//   DAC_LDAC_EN  adds the active-low ldac strobe, low for CLK_DIV cycles from
//                the cs rising edge; GAP then lasts max(CS_HIGH_CYC, CLK_DIV).
// Ports
//   clk          in   1       system clock
//   reset        in   1       synchronous, active-high reset; aborts a frame
//   dato         in   DATA_W  sample, sampled on the accept edge only
//   dato_valido  in   1       sample available
//   listo        out  1       ready; accept on dato_valido && listo
//   cs           out  1       DAC chip select, active low
//   sclk         out  1       serial clock, idles low
//   sdata        out  1       serial data, changes only while sclk is low
//   ldac         out  1       DAC latch strobe, active low (DAC_LDAC_EN only)

module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned CS_HIGH_CYC = CS_HIGH_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dato,
    input  logic              dato_valido,
    output logic              listo,
    output logic              cs,
    output logic              sclk,
    output logic              sdata
`ifdef DAC_LDAC_EN
    ,
    output logic              ldac
`endif
);

`ifdef DAC_LDAC_EN
    localparam int unsigned GAP_CYC = max_u(CS_HIGH_CYC, CLK_DIV);
`else
    localparam int unsigned GAP_CYC = CS_HIGH_CYC;
`endif
    localparam int unsigned CNT_W = cnt_width(max_u(CLK_DIV, GAP_CYC));
    localparam int unsigned BIT_W = cnt_width(DATA_W);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

    state_t              state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
    logic                phase_hi, phase_hi_n;
    logic                cs_n, sclk_n, sdata_n, listo_n;
    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic                tick;
`ifdef DAC_LDAC_EN
    logic                ldac_n;
    logic [CNT_W-1:0]    ldac_cnt, ldac_cnt_n;
`endif

    sclk_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            cs       <= 1'b1;
            sclk     <= 1'b0;
            sdata    <= 1'b0;
            listo    <= 1'b1;
`ifdef DAC_LDAC_EN
            ldac     <= 1'b1;
            ldac_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            phase_hi <= phase_hi_n;
            cs       <= cs_n;
            sclk     <= sclk_n;
            sdata    <= sdata_n;
            listo    <= listo_n;
`ifdef DAC_LDAC_EN
            ldac     <= ldac_n;
            ldac_cnt <= ldac_cnt_n;
`endif
        end
    end

    // Next-state logic computes the value every output takes after the coming
    // edge, so outputs stay registered while switching on the same edge as
    // the state they belong to.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        phase_hi_n = phase_hi;
        cs_n       = cs;
        sclk_n     = sclk;
        sdata_n    = sdata;
        listo_n    = listo;
        cnt_load   = 1'b0;
        cnt_val    = HALF_LOAD;
`ifdef DAC_LDAC_EN
        ldac_n     = ldac;
        ldac_cnt_n = ldac_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (dato_valido && listo) begin
                    state_n   = ST_SETUP;
                    shreg_n   = dato;
                    bit_cnt_n = '0;
                    listo_n   = 1'b0;
                    cs_n      = 1'b0;
                    sclk_n    = 1'b0;
                    sdata_n   = dato[DATA_W-1];
                    cnt_load  = 1'b1;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    state_n    = ST_SHIFT;
                    phase_hi_n = 1'b0;
                    sdata_n    = shreg[DATA_W-1];
                    cnt_load   = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    cnt_load = 1'b1;
                    if (!phase_hi) begin
                        sclk_n     = 1'b1;
                        phase_hi_n = 1'b1;
                    end else if (bit_cnt == LAST_BIT) begin
                        state_n    = ST_HOLD;
                        sclk_n     = 1'b0;
                        sdata_n    = 1'b0;
                        phase_hi_n = 1'b0;
                        bit_cnt_n  = '0;
                    end else begin
                        // Falling sclk: advance to the next bit while sclk is low.
                        sclk_n     = 1'b0;
                        phase_hi_n = 1'b0;
                        shreg_n    = {shreg[DATA_W-2:0], 1'b0};
                        sdata_n    = shreg[DATA_W-2];
                        bit_cnt_n  = bit_cnt + BIT_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (tick) begin
                    state_n  = ST_GAP;
                    cs_n     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = GAP_LOAD;
`ifdef DAC_LDAC_EN
                    ldac_n     = 1'b0;
                    ldac_cnt_n = HALF_LOAD;
`endif
                end
            end

            ST_GAP: begin
`ifdef DAC_LDAC_EN
                // ldac has its own countdown because the shared counter is
                // busy timing the (possibly longer) gap.
                if (!ldac) begin
                    if (ldac_cnt == '0) begin
                        ldac_n = 1'b1;
                    end else begin
                        ldac_cnt_n = ldac_cnt - CNT_W'(1);
                    end
                end
`endif
                if (tick) begin
                    state_n = ST_IDLE;
                    listo_n = 1'b1;
`ifdef DAC_LDAC_EN
                    ldac_n  = 1'b1;
`endif
                end
            end

            default: begin
                state_n = ST_IDLE;
                cs_n    = 1'b1;
                sclk_n  = 1'b0;
                sdata_n = 1'b0;
                listo_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx
//   Directed bench for dac_spi_tx with DATA_W=16, CLK_DIV=2, CS_HIGH_CYC=3.
//   Log index i holds the outputs sampled 1 ns after the i-th clock edge of an
//   observation window, where edge 0 is the accept edge. With these settings:
//   SETUP = edges 0..1, bit k rises at index 4+4k, HOLD from 66, GAP 68..70,
//   listo high again from index 71. Define DAC_LDAC_EN to cover ldac.

module tb_dac_spi_tx;

    localparam int unsigned DW = 16;
    localparam int unsigned CD = 2;
    localparam int unsigned CH = 3;
    localparam int          NOPULSE = 100000;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] dato;
    logic          dato_valido;
    logic          listo, cs, sclk, sdata;
`ifdef DAC_LDAC_EN
    logic          ldac;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic cs_log    [0:255];
    logic sclk_log  [0:255];
    logic sdata_log [0:255];
    logic listo_log [0:255];
    logic ldac_log  [0:255];

    always #5 clk = ~clk;

    dac_spi_tx #(
        .DATA_W      (DW),
        .CLK_DIV     (CD),
        .CS_HIGH_CYC (CH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dato        (dato),
        .dato_valido (dato_valido),
        .listo       (listo),
        .cs          (cs),
        .sclk        (sclk),
        .sdata       (sdata)
`ifdef DAC_LDAC_EN
        ,
        .ldac        (ldac)
`endif
    );

    // Records n cycles; edge 0 is the first edge. Inputs are changed after
    // the sample: dato after edge 0, valid dropped after edge drop_at, and an
    // optional one-cycle valid pulse carrying pulse_dato after edge pulse_at.
    task automatic observe(input int n, input int drop_at, input logic [DW-1:0] dato_after,
                           input int pulse_at, input logic [DW-1:0] pulse_dato);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cs_log[i]    = cs;
            sclk_log[i]  = sclk;
            sdata_log[i] = sdata;
            listo_log[i] = listo;
`ifdef DAC_LDAC_EN
            ldac_log[i]  = ldac;
`else
            ldac_log[i]  = 1'b1;
`endif
            if (i == 0) dato = dato_after;
            if (i == drop_at) dato_valido = 1'b0;
            if (i == pulse_at) begin
                dato_valido = 1'b1;
                dato        = pulse_dato;
            end else if (i == pulse_at + 1) begin
                dato_valido = 1'b0;
            end
        end
    endtask

    function automatic int count_rises(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i < hi; i++) begin
            logic prev;
            prev = (i == 0) ? 1'b0 : sclk_log[i-1];
            if (sclk_log[i] && !prev) c++;
        end
        return c;
    endfunction

    function automatic logic [DW-1:0] decode(input int lo, input int hi);
        logic [DW-1:0] w = '0;
        for (int i = lo; i < hi; i++) begin
            logic prev;
            prev = (i == 0) ? 1'b0 : sclk_log[i-1];
            if (sclk_log[i] && !prev) w = {w[DW-2:0], sdata_log[i]};
        end
        return w;
    endfunction

    function automatic int first_rise(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            logic prev;
            prev = (i == 0) ? 1'b0 : sclk_log[i-1];
            if (sclk_log[i] && !prev) return i;
        end
        return -1;
    endfunction

    function automatic int first_listo(input int lo, input int hi);
        for (int i = lo; i < hi; i++) if (listo_log[i]) return i;
        return -1;
    endfunction

    function automatic int first_cs_high(input int lo, input int hi);
        for (int i = lo; i < hi; i++) if (cs_log[i]) return i;
        return -1;
    endfunction

    function automatic int count_cs_high(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i < hi; i++) if (cs_log[i]) c++;
        return c;
    endfunction

    function automatic int count_ldac_low(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i < hi; i++) if (!ldac_log[i]) c++;
        return c;
    endfunction

    // sdata changing on a cycle where sclk is high means it moved at or during
    // the high phase.
    function automatic int sdata_bad_changes(input int lo, input int hi);
        int c = 0;
        for (int i = lo + 1; i < hi; i++)
            if ((sdata_log[i] != sdata_log[i-1]) && sclk_log[i]) c++;
        return c;
    endfunction

    task automatic test_reset();
        logic [3:0] got;
        reset       = 1'b1;
        dato_valido = 1'b0;
        dato        = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = {listo, cs, sclk, sdata};
            n_checks++;
            if (got !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_cycle%0d: {listo,cs,sclk,sdata} got %b expected 1100", i, got);
            end
`ifdef DAC_LDAC_EN
            n_checks++;
            if (ldac !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ldac%0d: got %b expected 1", i, ldac);
            end
`endif
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            got = {listo, cs, sclk, sdata};
            n_checks++;
            if (got !== 4'b1100) begin
                n_fail++;
                $display("FAIL post_reset%0d: {listo,cs,sclk,sdata} got %b expected 1100", i, got);
            end
        end
    endtask

    task automatic test_single_frame();
        int v;
        dato        = 16'hA5C3;
        dato_valido = 1'b1;
        observe(80, 0, 16'h0000, NOPULSE, '0);

        n_checks++;
        if ({cs_log[0], listo_log[0], sdata_log[0]} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_accept: {cs,listo,sdata} got %b expected 001",
                     {cs_log[0], listo_log[0], sdata_log[0]});
        end
        v = first_rise(0, 80);
        n_checks++;
        if (v != 4) begin
            n_fail++;
            $display("FAIL single_first_rise: got index %0d expected 4", v);
        end
        v = count_rises(0, 80);
        n_checks++;
        if (v != 16) begin
            n_fail++;
            $display("FAIL single_rises: got %0d expected 16", v);
        end
        n_checks++;
        if (decode(0, 80) !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL single_word: got %h expected a5c3", decode(0, 80));
        end
        v = first_listo(1, 80);
        n_checks++;
        if (v != 71) begin
            n_fail++;
            $display("FAIL single_listo: got index %0d expected 71", v);
        end
        v = first_cs_high(1, 80);
        n_checks++;
        if (v != 68) begin
            n_fail++;
            $display("FAIL single_cs_rise: got index %0d expected 68", v);
        end
        n_checks++;
        if ({sclk_log[66], sdata_log[66], cs_log[66]} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_hold: {sclk,sdata,cs} got %b expected 000",
                     {sclk_log[66], sdata_log[66], cs_log[66]});
        end
        v = sdata_bad_changes(0, 80);
        n_checks++;
        if (v != 0) begin
            n_fail++;
            $display("FAIL single_sdata_stable: got %0d changes with sclk high expected 0", v);
        end
        v = count_ldac_low(0, 68);
        n_checks++;
        if (v != 0) begin
            n_fail++;
            $display("FAIL single_ldac_quiet: got %0d low cycles expected 0", v);
        end
    endtask

    task automatic test_back_to_back();
        int v;
        dato        = 16'h0001;
        dato_valido = 1'b1;
        observe(150, 72, 16'h8000, NOPULSE, '0);

        n_checks++;
        if (decode(0, 72) !== 16'h0001) begin
            n_fail++;
            $display("FAIL b2b_word1: got %h expected 0001", decode(0, 72));
        end
        n_checks++;
        if (decode(72, 150) !== 16'h8000) begin
            n_fail++;
            $display("FAIL b2b_word2: got %h expected 8000", decode(72, 150));
        end
        v = count_rises(72, 150);
        n_checks++;
        if (v != 16) begin
            n_fail++;
            $display("FAIL b2b_rises2: got %0d expected 16", v);
        end
        // GAP (3 cycles) plus the single IDLE cycle on which the next accept happens.
        v = count_cs_high(0, 72);
        n_checks++;
        if (v != 4) begin
            n_fail++;
            $display("FAIL b2b_cs_gap: got %0d cycles expected 4", v);
        end
        n_checks++;
        if ({cs_log[71], listo_log[71], cs_log[72], listo_log[72]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_reaccept: {cs71,listo71,cs72,listo72} got %b expected 1100",
                     {cs_log[71], listo_log[71], cs_log[72], listo_log[72]});
        end
        v = first_listo(73, 150);
        n_checks++;
        if (v != 143) begin
            n_fail++;
            $display("FAIL b2b_listo2: got index %0d expected 143", v);
        end
    endtask

    task automatic test_ignore_busy_valid();
        int v;
        dato        = 16'h3C5A;
        dato_valido = 1'b1;
        observe(100, 0, 16'h0000, 20, 16'hFFFF);

        n_checks++;
        if (decode(0, 100) !== 16'h3C5A) begin
            n_fail++;
            $display("FAIL busy_word: got %h expected 3c5a", decode(0, 100));
        end
        v = count_rises(0, 100);
        n_checks++;
        if (v != 16) begin
            n_fail++;
            $display("FAIL busy_rises: got %0d expected 16", v);
        end
        v = first_listo(1, 100);
        n_checks++;
        if (v != 71) begin
            n_fail++;
            $display("FAIL busy_listo: got index %0d expected 71", v);
        end
        v = count_cs_high(68, 100);
        n_checks++;
        if (v != 32) begin
            n_fail++;
            $display("FAIL busy_no_extra_frame: cs high %0d cycles expected 32", v);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v;
        logic [3:0] got;
        dato        = 16'hAAAA;
        dato_valido = 1'b1;
        observe(29, 0, 16'h0000, NOPULSE, '0);
        v = count_rises(0, 29);
        n_checks++;
        if (v != 7 || sclk_log[28] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup: rises got %0d sclk %b expected 7 and 1", v, sclk_log[28]);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        got = {cs, sclk, listo, sdata};
        n_checks++;
        if (got !== 4'b1010) begin
            n_fail++;
            $display("FAIL abort_reset: {cs,sclk,listo,sdata} got %b expected 1010", got);
        end
        reset = 1'b0;
        observe(3, 0, 16'h0000, NOPULSE, '0);
        v = count_rises(0, 3) + count_cs_high(0, 3);
        n_checks++;
        if (v != 3) begin
            n_fail++;
            $display("FAIL abort_quiet: rises+cs_high got %0d expected 3", v);
        end
        dato        = 16'h1234;
        dato_valido = 1'b1;
        observe(80, 0, 16'h0000, NOPULSE, '0);
        n_checks++;
        if (decode(0, 80) !== 16'h1234 || count_rises(0, 80) != 16) begin
            n_fail++;
            $display("FAIL abort_new_frame: word %h rises %0d expected 1234 and 16",
                     decode(0, 80), count_rises(0, 80));
        end
        v = first_listo(1, 80);
        n_checks++;
        if (v != 71) begin
            n_fail++;
            $display("FAIL abort_new_listo: got index %0d expected 71", v);
        end
    endtask

`ifdef DAC_LDAC_EN
    task automatic test_ldac();
        int v;
        dato        = 16'h00FF;
        dato_valido = 1'b1;
        observe(80, 0, 16'h0000, NOPULSE, '0);
        n_checks++;
        if (decode(0, 80) !== 16'h00FF) begin
            n_fail++;
            $display("FAIL ldac_word: got %h expected 00ff", decode(0, 80));
        end
        v = count_ldac_low(0, 80);
        n_checks++;
        if (v != 2) begin
            n_fail++;
            $display("FAIL ldac_width: got %0d low cycles expected 2", v);
        end
        n_checks++;
        if ({ldac_log[67], ldac_log[68], ldac_log[69], ldac_log[70], cs_log[68]} !== 5'b10011) begin
            n_fail++;
            $display("FAIL ldac_align: {ldac67..70,cs68} got %b expected 10011",
                     {ldac_log[67], ldac_log[68], ldac_log[69], ldac_log[70], cs_log[68]});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignore_busy_valid();
        test_reset_mid_frame();
`ifdef DAC_LDAC_EN
        test_ldac();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
